onehot_scan_encoder: RTL and testbench
======================================

Name: onehot_scan_encoder

Overview:
- Inverse of the 5-to-32 register-select decoder: accepts a 32-bit bit-vector and emits the 5-bit index of every set bit, one index per handshake, lowest index first by default.
- Used by the writeback/debug path to walk a register-enable or pending mask and return register numbers.
- Input side is valid/ready; output side is valid/ready.
- All outputs come from registered state only; there is no input-to-output combinational path.

Parameters:
- MSB_FIRST, 0, scan order: 0 emits indices from lowest to highest, 1 emits them from highest to lowest.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous abort; discards any vector in progress.
- vec_i  input  32  bit-vector to encode.
- vec_valid_i  input  1  vec_i is valid.
- vec_ready_o  output  1  block can accept a vector.
- idx_o  output  5  index of the current set bit.
- idx_valid_o  output  1  idx_o is valid.
- idx_ready_i  input  1  downstream consumes idx_o.
- last_o  output  1  idx_o is the final index of the current vector; qualified by idx_valid_o.
- zero_o  output  1  one-cycle pulse: an all-zero vector was accepted.
- cnt_o  output  6  number of set bits remaining, including the current one (0..32).

Behaviour:
- State machine has two states: IDLE and SCAN. Internal 32-bit pending register.
- Reset (rst_ni low, asynchronous):
  - state = IDLE, pending = 0.
  - idx_o = 0, idx_valid_o = 0, last_o = 0, zero_o = 0, cnt_o = 0.
  - vec_ready_o = 1 (it equals state==IDLE); inputs are ignored while in reset.
- IDLE:
  - vec_ready_o = 1, idx_valid_o = 0.
  - Accept happens on vec_valid_i & vec_ready_o at a rising edge.
  - vec_i != 0: pending <= vec_i, cnt <= popcount(vec_i), go to SCAN.
  - vec_i == 0: stay in IDLE, pulse zero_o high for exactly the next cycle, emit no index.
- SCAN:
  - vec_ready_o = 0, idx_valid_o = 1.
  - idx_o = lowest set bit of pending (highest set bit if MSB_FIRST=1).
  - last_o = (cnt_o == 1).
  - Latency: a vector accepted at edge N gives idx_valid_o = 1 in the cycle after edge N.
  - Output handshake: idx_valid_o & idx_ready_i at an edge clears that bit in pending and decrements cnt.
  - Handshake while last_o = 1: go to IDLE; vec_ready_o = 1 the next cycle. A new vector cannot be accepted in that same cycle, so there is one bubble cycle.
  - idx_ready_i low: idx_o, last_o and cnt_o hold stable. idx_valid_o never drops without a handshake, except on flush or reset.
- flush_i:
  - At an edge it forces IDLE, pending = 0, cnt = 0, zero_o = 0.
  - Flush has priority over a simultaneous output handshake and over a simultaneous vector accept; the vector is not taken.
- Reset mid-scan: immediately returns to the reset values; the partially emitted vector is lost.
- Vector of all ones: emits 32 indices, 0..31 (31..0 if MSB_FIRST=1). cnt_o = 32 on entry; last_o is set on index 31 (index 0 if MSB_FIRST=1).
- Index arithmetic:
  - idx_o is 5 bits, so every index in 0..31 is representable with no wrap.
  - cnt_o is 6 bits so that it can hold the value 32.

Test Plan:
- Sparse vector: reset, vec_i=0x8000_0011 with idx_ready_i=1 → idx_o 0, 4, 31 on consecutive cycles; last_o only with 31; cnt_o 3, 2, 1; vec_ready_o=1 the cycle after the final handshake.
- Zero vector: accept vec_i=0 → zero_o high for exactly 1 cycle, idx_valid_o stays 0, vec_ready_o stays 1.
- Backpressure: vec_i=0x0000_0006, idx_ready_i low for 3 cycles → idx_o=1 held stable with cnt_o=2; after release, idx_o=2 with last_o=1.
- Order and full vector: MSB_FIRST=1, vec_i=0xFFFF_FFFF → 32 indices 31 down to 0; cnt_o starts at 32; last_o on index 0.
- Flush collision: in SCAN with idx_ready_i=1 and flush_i=1 in the same cycle → next cycle IDLE, idx_valid_o=0, cnt_o=0; a vector presented in that flush cycle is not accepted.
- Async reset mid-scan: drop rst_ni between clock edges during vec_i=0x0000_F000 → all outputs at reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/onehot_scan_encoder.sv
// Walks a 32-bit mask and returns the index of each set bit, one per output handshake.
// Scan order is selectable; all outputs are driven from registered state.
module onehot_scan_encoder #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic [31:0] vec_i,
    input  logic        vec_valid_i,
    output logic        vec_ready_o,
    output logic [4:0]  idx_o,
    output logic        idx_valid_o,
    input  logic        idx_ready_i,
    output logic        last_o,
    output logic        zero_o,
    output logic [5:0]  cnt_o
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t      r_state;
    logic [31:0] r_pending;
    logic [4:0]  r_idx;
    logic [5:0]  r_cnt;
    logic        r_last;
    logic        r_zero;

    logic [31:0] w_pend_clr;
    logic [5:0]  w_vec_cnt;
    logic [4:0]  w_vec_idx;
    logic [4:0]  w_next_idx;

    // Later matches overwrite earlier ones, so the loop direction picks the scan order.
    function automatic logic [4:0] find_idx(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < 32; i++) begin
                if (v[i]) idx = 5'(i);
            end
        end else begin
            for (int i = 31; i >= 0; i--) begin
                if (v[i]) idx = 5'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

    always_comb begin
        w_pend_clr = r_pending & ~(32'd1 << r_idx);
        w_vec_cnt  = popcount(vec_i);
        w_vec_idx  = find_idx(vec_i);
        w_next_idx = find_idx(w_pend_clr);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_last    <= 1'b0;
            r_zero    <= 1'b0;
        end else if (flush_i) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_last    <= 1'b0;
            r_zero    <= 1'b0;
        end else begin
            r_zero <= 1'b0;
            if (r_state == IDLE) begin
                if (vec_valid_i) begin
                    if (vec_i != 32'd0) begin
                        r_state   <= SCAN;
                        r_pending <= vec_i;
                        r_cnt     <= w_vec_cnt;
                        r_idx     <= w_vec_idx;
                        r_last    <= (w_vec_cnt == 6'd1);
                    end else begin
                        r_zero <= 1'b1;
                    end
                end
            end else if (idx_ready_i) begin
                if (r_last) begin
                    r_state   <= IDLE;
                    r_pending <= '0;
                    r_idx     <= '0;
                    r_cnt     <= '0;
                    r_last    <= 1'b0;
                end else begin
                    r_pending <= w_pend_clr;
                    r_cnt     <= r_cnt - 6'd1;
                    r_idx     <= w_next_idx;
                    r_last    <= (r_cnt == 6'd2);
                end
            end
        end
    end

    assign vec_ready_o = (r_state == IDLE);
    assign idx_valid_o = (r_state == SCAN);
    assign idx_o       = r_idx;
    assign last_o      = r_last;
    assign zero_o      = r_zero;
    assign cnt_o       = r_cnt;

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// Directed bench for onehot_scan_encoder: one LSB-first and one MSB-first instance
// share the same stimulus; expected values are hand-derived per step.
module tb_onehot_scan_encoder;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] vec;
    logic        vec_valid;
    logic        idx_ready;

    logic        l_vec_ready, l_idx_valid, l_last, l_zero;
    logic [4:0]  l_idx;
    logic [5:0]  l_cnt;
    logic        m_vec_ready, m_idx_valid, m_last, m_zero;
    logic [4:0]  m_idx;
    logic [5:0]  m_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    onehot_scan_encoder #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .vec_i(vec), .vec_valid_i(vec_valid), .vec_ready_o(l_vec_ready),
        .idx_o(l_idx), .idx_valid_o(l_idx_valid), .idx_ready_i(idx_ready),
        .last_o(l_last), .zero_o(l_zero), .cnt_o(l_cnt)
    );

    onehot_scan_encoder #(.MSB_FIRST(1'b1)) dut_msb (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .vec_i(vec), .vec_valid_i(vec_valid), .vec_ready_o(m_vec_ready),
        .idx_o(m_idx), .idx_valid_o(m_idx_valid), .idx_ready_i(idx_ready),
        .last_o(m_last), .zero_o(m_zero), .cnt_o(m_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_lsb_idle(input string tag);
        check({tag, ".vec_ready"}, 32'(l_vec_ready), 32'd1);
        check({tag, ".idx_valid"}, 32'(l_idx_valid), 32'd0);
        check({tag, ".cnt"},       32'(l_cnt),       32'd0);
        check({tag, ".last"},      32'(l_last),      32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        vec       = '0;
        vec_valid = 1'b0;
        idx_ready = 1'b0;

        // Reset state
        #2;
        check_lsb_idle("rst");
        check("rst.idx",  32'(l_idx),  32'd0);
        check("rst.zero", 32'(l_zero), 32'd0);
        check("rst.msb_ready", 32'(m_vec_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();

        // Sparse vector, LSB first: 0, 4, 31
        vec = 32'h8000_0011; vec_valid = 1'b1; idx_ready = 1'b1;
        step();
        vec_valid = 1'b0;
        check("sp0.valid", 32'(l_idx_valid), 32'd1);
        check("sp0.ready", 32'(l_vec_ready), 32'd0);
        check("sp0.idx",   32'(l_idx),  32'd0);
        check("sp0.cnt",   32'(l_cnt),  32'd3);
        check("sp0.last",  32'(l_last), 32'd0);
        check("sp0.msb_idx", 32'(m_idx), 32'd31);
        step();
        check("sp1.idx",  32'(l_idx),  32'd4);
        check("sp1.cnt",  32'(l_cnt),  32'd2);
        check("sp1.last", 32'(l_last), 32'd0);
        check("sp1.msb_idx", 32'(m_idx), 32'd4);
        step();
        check("sp2.idx",  32'(l_idx),  32'd31);
        check("sp2.cnt",  32'(l_cnt),  32'd1);
        check("sp2.last", 32'(l_last), 32'd1);
        check("sp2.msb_idx", 32'(m_idx), 32'd0);
        step();
        check_lsb_idle("sp3");

        // Zero vector
        vec = 32'h0; vec_valid = 1'b1;
        step();
        vec_valid = 1'b0;
        check("z0.zero",  32'(l_zero),      32'd1);
        check("z0.valid", 32'(l_idx_valid), 32'd0);
        check("z0.ready", 32'(l_vec_ready), 32'd1);
        step();
        check("z1.zero",  32'(l_zero),      32'd0);
        check("z1.valid", 32'(l_idx_valid), 32'd0);

        // Backpressure: 0x6 held at index 1 for 3 cycles
        vec = 32'h0000_0006; vec_valid = 1'b1; idx_ready = 1'b0;
        step();
        vec_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp.valid", 32'(l_idx_valid), 32'd1);
            check("bp.idx",   32'(l_idx),  32'd1);
            check("bp.cnt",   32'(l_cnt),  32'd2);
            check("bp.last",  32'(l_last), 32'd0);
            if (i < 2) step();
        end
        idx_ready = 1'b1;
        step();
        check("bp.idx2",  32'(l_idx),  32'd2);
        check("bp.cnt2",  32'(l_cnt),  32'd1);
        check("bp.last2", 32'(l_last), 32'd1);
        step();
        check_lsb_idle("bp.end");

        // Full vector in both orders
        vec = 32'hFFFF_FFFF; vec_valid = 1'b1; idx_ready = 1'b1;
        step();
        vec_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("full.msb_idx",  32'(m_idx),  32'(31 - i));
            check("full.msb_cnt",  32'(m_cnt),  32'(32 - i));
            check("full.msb_last", 32'(m_last), (i == 31) ? 32'd1 : 32'd0);
            check("full.lsb_idx",  32'(l_idx),  32'(i));
            check("full.lsb_valid", 32'(l_idx_valid), 32'd1);
            step();
        end
        check("full.msb_ready", 32'(m_vec_ready), 32'd1);
        check("full.msb_valid", 32'(m_idx_valid), 32'd0);
        check_lsb_idle("full.end");

        // Flush colliding with an output handshake and a presented vector
        vec = 32'h0000_00F0; vec_valid = 1'b1; idx_ready = 1'b1;
        step();
        check("fl.scan", 32'(l_idx), 32'd4);
        vec = 32'h0000_0003; flush = 1'b1;
        step();
        flush = 1'b0; vec_valid = 1'b0;
        check_lsb_idle("fl.hs");
        step();
        check("fl.noacc", 32'(l_idx_valid), 32'd0);
        // Flush while IDLE beats a simultaneous accept
        vec = 32'h0000_0005; vec_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; vec_valid = 1'b0;
        check_lsb_idle("fl.idle");
        check("fl.idle_zero", 32'(l_zero), 32'd0);
        // Flush suppresses a zero-vector pulse
        vec = 32'h0; vec_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; vec_valid = 1'b0;
        check("fl.zero", 32'(l_zero), 32'd0);

        // Asynchronous reset mid-scan
        vec = 32'h0000_F000; vec_valid = 1'b1; idx_ready = 1'b1;
        step();
        vec_valid = 1'b0;
        check("ar.idx0", 32'(l_idx), 32'd12);
        check("ar.cnt0", 32'(l_cnt), 32'd4);
        step();
        check("ar.idx1", 32'(l_idx), 32'd13);
        #2;
        rst_n = 1'b0;
        #1;
        check_lsb_idle("ar");
        check("ar.idx", 32'(l_idx), 32'd0);
        check("ar.msb_valid", 32'(m_idx_valid), 32'd0);
        #3;
        rst_n = 1'b1;
        step();
        check_lsb_idle("ar.post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
